// File: rtl/mips_pkg.sv
// Shared pipeline definitions: instruction field positions and the shadow slot
// tracked by the hazard unit for each in-flight instruction.
package mips_pkg;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       wr;
    logic       ld;
  } shadow_slot_t;

  // A slot only produces a forwardable value if it is live, writes, and is not $0.
  function automatic logic slot_hit(input shadow_slot_t s, input logic [4:0] src);
    return s.v & s.wr & (s.dest != REG_ZERO) & (s.dest == src);
  endfunction

endpackage

// File: rtl/hazard_dest_pipe.sv
// Two-slot shadow of destination registers: S1 mirrors IF/ID, S2 mirrors ID/EX.
module hazard_dest_pipe
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  shadow_slot_t s1_d,
  output shadow_slot_t s1_q,
  output shadow_slot_t s2_q
);

  shadow_slot_t s2_d;

  always_comb begin
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall generator for the 5-stage datapath; the
// selects are computed one stage early and registered into IF/ID by the datapath.
module hazard_forward_unit
  import mips_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [31:0]      instr,
  input  logic             reg_wr,
  input  logic             reg_dst,
  input  logic             mem_to_reg,
  input  logic             mem_wr,
  input  logic             alu_src,
  output logic             ex_forward_a,
  output logic             ex_forward_b,
  output logic             mem_forward_a,
  output logic             mem_forward_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic [REG_AW-1:0] rs, rt, rd, dest;
  logic              use_a, use_b;
  logic              hit1_a, hit1_b, hit2_a, hit2_b;
  shadow_slot_t      s1_d, s1_q, s2_q;
  logic [CNT_W-1:0]  stall_count_d, stall_count_q;
  logic              unused_ok;

  assign rs        = instr[RS_MSB:RS_LSB];
  assign rt        = instr[RT_MSB:RT_LSB];
  assign rd        = instr[RD_MSB:RD_LSB];
  assign dest      = reg_dst ? rd : rt;
  assign unused_ok = ^{instr[31:26], instr[10:0], s2_q.ld};

  // Rt is a source for R-type and for stores (store data), never for plain immediates.
  assign use_a = issue_valid;
  assign use_b = issue_valid & (~alu_src | mem_wr);

  assign hit1_a = use_a & slot_hit(s1_q, rs);
  assign hit1_b = use_b & slot_hit(s1_q, rt);
  assign hit2_a = use_a & slot_hit(s2_q, rs);
  assign hit2_b = use_b & slot_hit(s2_q, rt);

  // A load in S1 only has its address in ALUout, so the consumer must wait one cycle.
  assign stall = (hit1_a | hit1_b) & s1_q.ld;

  assign ex_forward_a  = hit1_a & ~s1_q.ld & ~stall;
  assign ex_forward_b  = hit1_b & ~s1_q.ld & ~stall;
  assign mem_forward_a = hit2_a & ~stall;
  assign mem_forward_b = hit2_b & ~stall;

  always_comb begin
    s1_d.v    = issue_valid & ~stall;
    s1_d.dest = dest;
    s1_d.wr   = reg_wr;
    s1_d.ld   = mem_to_reg;
  end

  hazard_dest_pipe u_dest_pipe (
    .clk  (clk),
    .rst  (rst),
    .s1_d (s1_d),
    .s1_q (s1_q),
    .s2_q (s2_q)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_count_q <= '0;
    else      stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed checks of forwarding selects, load-use stall and stall statistics.
module tb_hazard_forward_unit;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [31:0]      instr;
  logic             reg_wr, reg_dst, mem_to_reg, mem_wr, alu_src;
  logic             ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall;
  logic [CNT_W-1:0] stall_count;
  logic [4:0]       sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.CNT_W(CNT_W), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .instr        (instr),
    .reg_wr       (reg_wr),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .mem_wr       (mem_wr),
    .alu_src      (alu_src),
    .ex_forward_a (ex_forward_a),
    .ex_forward_b (ex_forward_b),
    .mem_forward_a(mem_forward_a),
    .mem_forward_b(mem_forward_b),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  // {ex_a, ex_b, mem_a, mem_b, stall}
  assign sel = {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; instr = '0;
    reg_wr = 0; reg_dst = 0; mem_to_reg = 0; mem_wr = 0; alu_src = 0;
  endtask

  task automatic drive_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    issue_valid = 1'b1; instr = {6'h00, rs, rt, rd, 5'd0, 6'h20};
    reg_wr = 1; reg_dst = 1; mem_to_reg = 0; mem_wr = 0; alu_src = 0;
  endtask

  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    issue_valid = 1'b1; instr = {6'h23, rs, rt, 16'd0};
    reg_wr = 1; reg_dst = 0; mem_to_reg = 1; mem_wr = 0; alu_src = 1;
  endtask

  task automatic drive_sw(input logic [4:0] rs, input logic [4:0] rt);
    issue_valid = 1'b1; instr = {6'h2b, rs, rt, 16'd4};
    reg_wr = 0; reg_dst = 0; mem_to_reg = 0; mem_wr = 1; alu_src = 1;
  endtask

  task automatic drive_addi(input logic [4:0] rs, input logic [4:0] rt);
    issue_valid = 1'b1; instr = {6'h08, rs, rt, 16'd5};
    reg_wr = 1; reg_dst = 0; mem_to_reg = 0; mem_wr = 0; alu_src = 1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle();
    tick();
    do_reset();
    #1;
    checks++;
    if (sel !== 5'b00000) begin
      failures++; $display("FAIL reset_sel got=%b want=%b", sel, 5'b00000);
    end
    checks++;
    if (stall_count !== '0) begin
      failures++; $display("FAIL reset_cnt got=%0d want=0", stall_count);
    end
  endtask

  task automatic test_ex_forward();
    do_reset();
    drive_r(5'd1, 5'd2, 5'd3); tick();
    drive_r(5'd3, 5'd3, 5'd4); #1;
    checks++;
    if (sel !== 5'b11000) begin
      failures++; $display("FAIL ex_fwd_ab got=%b want=%b", sel, 5'b11000);
    end
  endtask

  task automatic test_mem_forward();
    do_reset();
    drive_r(5'd1, 5'd2, 5'd3); tick();
    drive_r(5'd0, 5'd0, 5'd0); tick();
    drive_r(5'd3, 5'd6, 5'd5); #1;
    checks++;
    if (sel !== 5'b00100) begin
      failures++; $display("FAIL mem_fwd_a got=%b want=%b", sel, 5'b00100);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_lw(5'd1, 5'd3); tick();
    drive_r(5'd3, 5'd2, 5'd4); #1;
    checks++;
    if (sel !== 5'b00001) begin
      failures++; $display("FAIL lu_stall got=%b want=%b", sel, 5'b00001);
    end
    tick();
    #1;
    checks++;
    if (sel !== 5'b00100) begin
      failures++; $display("FAIL lu_represent got=%b want=%b", sel, 5'b00100);
    end
    checks++;
    if (stall_count !== 8'd1) begin
      failures++; $display("FAIL lu_count got=%0d want=1", stall_count);
    end
    tick();
    // Second dependent instruction is at distance 3 from the load: no action here.
    drive_r(5'd3, 5'd3, 5'd5); #1;
    checks++;
    if (sel !== 5'b00000) begin
      failures++; $display("FAIL lu_second got=%b want=%b", sel, 5'b00000);
    end
    tick(); #1;
    checks++;
    if (stall_count !== 8'd1) begin
      failures++; $display("FAIL lu_count_once got=%0d want=1", stall_count);
    end
  endtask

  task automatic test_zero_and_imm();
    do_reset();
    drive_r(5'd1, 5'd2, 5'd0); tick();
    drive_r(5'd0, 5'd0, 5'd4); #1;
    checks++;
    if (sel !== 5'b00000) begin
      failures++; $display("FAIL zero_reg got=%b want=%b", sel, 5'b00000);
    end
    tick();
    drive_r(5'd1, 5'd2, 5'd7); tick();
    drive_addi(5'd3, 5'd7); #1;
    checks++;
    if (sel !== 5'b00000) begin
      failures++; $display("FAIL addi_rt got=%b want=%b", sel, 5'b00000);
    end
  endtask

  task automatic test_store_and_dual();
    do_reset();
    drive_r(5'd1, 5'd2, 5'd3); tick();
    drive_sw(5'd1, 5'd3); #1;
    checks++;
    if (sel !== 5'b01000) begin
      failures++; $display("FAIL sw_data got=%b want=%b", sel, 5'b01000);
    end
    do_reset();
    drive_r(5'd1, 5'd2, 5'd3); tick();
    drive_r(5'd1, 5'd2, 5'd3); tick();
    drive_r(5'd3, 5'd0, 5'd5); #1;
    checks++;
    if (sel !== 5'b10100) begin
      failures++; $display("FAIL dual_dist got=%b want=%b", sel, 5'b10100);
    end
  endtask

  task automatic test_invalid_issue();
    do_reset();
    drive_r(5'd1, 5'd2, 5'd3); tick();
    drive_r(5'd3, 5'd3, 5'd4); issue_valid = 1'b0; #1;
    checks++;
    if (sel !== 5'b00000) begin
      failures++; $display("FAIL invalid_out got=%b want=%b", sel, 5'b00000);
    end
    tick();
    drive_r(5'd3, 5'd3, 5'd4); #1;
    checks++;
    if (sel !== 5'b00110) begin
      failures++; $display("FAIL invalid_bubble got=%b want=%b", sel, 5'b00110);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 255; i++) begin
      drive_lw(5'd1, 5'd3); tick();
      drive_r(5'd3, 5'd2, 5'd4); tick();
    end
    checks++;
    if (stall_count !== 8'hFF) begin
      failures++; $display("FAIL sat_reach got=%0h want=ff", stall_count);
    end
    drive_lw(5'd1, 5'd3); tick();
    drive_r(5'd3, 5'd2, 5'd4); #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL sat_stall got=%b want=1", stall);
    end
    tick();
    checks++;
    if (stall_count !== 8'hFF) begin
      failures++; $display("FAIL sat_hold got=%0h want=ff", stall_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    tick();
    drive_lw(5'd1, 5'd3); tick();
    drive_r(5'd3, 5'd2, 5'd4); #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL rst_pre_stall got=%b want=1", stall);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1; #1;
    checks++;
    if (sel !== 5'b00000) begin
      failures++; $display("FAIL rst_mid_sel got=%b want=%b", sel, 5'b00000);
    end
    checks++;
    if (stall_count !== '0) begin
      failures++; $display("FAIL rst_mid_cnt got=%0d want=0", stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_zero_and_imm();
    test_store_and_dual();
    test_invalid_issue();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
